// File: rtl/classify_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// classify_pkg
// Shared types and constants for the output-node classifier sequencer.
//   cls_state_t : controller states (IDLE, COLLECT, RESULT)
//   NEG_MIN     : most negative 8-bit result, the starting running maximum
//   IDX_W       : width of node index / beat counter (up to 16 nodes)
// ---------------------------------------------------------------------------
package classify_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } cls_state_t;

  localparam int NEG_MIN = -128;
  localparam int IDX_W   = 4;

endpackage

// File: rtl/classify_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// classify_seq_ctrl_if
// Bundles the command, result-stream and classification handshakes of the
// classifier sequencer.
//   start / node_count / abort       : command from the NN control side
//   res_valid / res_data / res_ready : output-layer result stream
//   cls_valid / cls_ready            : held classification toward the ARM side
//   classification / max_value       : winning index and its value
//   busy                             : scan or result in progress
// Modports: master = environment side, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface classify_seq_ctrl_if #(
  parameter int DATA_W = 8
);

  logic                     start;
  logic [3:0]               node_count;
  logic                     abort;
  logic                     res_valid;
  logic signed [DATA_W-1:0] res_data;
  logic                     res_ready;
  logic                     cls_valid;
  logic                     cls_ready;
  logic [7:0]               classification;
  logic signed [DATA_W-1:0] max_value;
  logic                     busy;

  modport master (
    output start, node_count, abort, res_valid, res_data, cls_ready,
    input  res_ready, cls_valid, classification, max_value, busy
  );

  modport slave (
    input  start, node_count, abort, res_valid, res_data, cls_ready,
    output res_ready, cls_valid, classification, max_value, busy
  );

endinterface

// File: rtl/classify_seq_ctrl_argmax_step.sv
// ---------------------------------------------------------------------------
// argmax_step
// One combinational compare stage of the running argmax.
//   bestVal_i / bestIdx_i : current running maximum and its node index
//   resData_i / idx_i     : incoming result and its node index
//   bestVal_o / bestIdx_o : updated maximum and index
// ---------------------------------------------------------------------------
module argmax_step
  import classify_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] bestVal_i,
  input  logic        [IDX_W-1:0]  bestIdx_i,
  input  logic signed [DATA_W-1:0] resData_i,
  input  logic        [IDX_W-1:0]  idx_i,
  output logic signed [DATA_W-1:0] bestVal_o,
  output logic        [IDX_W-1:0]  bestIdx_o
);

  // Greater-or-equal lets a later node win a tie, and guarantees the very
  // first beat (even the most negative value) replaces the initial value.
  always_comb begin
    bestVal_o = bestVal_i;
    bestIdx_o = bestIdx_i;
    if (resData_i >= bestVal_i) begin
      bestVal_o = resData_i;
      bestIdx_o = idx_i;
    end
  end

endmodule

// File: rtl/classify_seq_ctrl.sv
// ---------------------------------------------------------------------------
// classify_seq_ctrl
// Sequencing controller for the output-node classifier. Accepts a start with
// a node count, scans one result per cycle while tracking the running maximum
// and its index, then holds the winning class until the consumer takes it.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : classify_seq_ctrl_if.slave (command, result stream, class out)
// ---------------------------------------------------------------------------
module classify_seq_ctrl
  import classify_pkg::*;
#(
  parameter int MAX_NODES = 16,
  parameter int DATA_W    = 8
) (
  input logic               clk,
  input logic               reset_n,
  classify_seq_ctrl_if.slave bus
);

  localparam logic [4:0] MAX_N = 5'(MAX_NODES);
  localparam logic signed [DATA_W-1:0] BEST_INIT = {1'b1, {(DATA_W-1){1'b0}}};

  cls_state_t               state_q, state_d;
  logic [4:0]               nodeCnt_q, nodeCnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] bestVal_q, bestVal_d;
  logic [IDX_W-1:0]         bestIdx_q, bestIdx_d;

  logic                     beatFire;
  logic                     lastBeat;
  logic [4:0]               decodedN;
  logic signed [DATA_W-1:0] stepVal;
  logic [IDX_W-1:0]         stepIdx;

  // A node_count of zero stands for a full 16-node scan; anything beyond the
  // configured node limit is clamped so the scan always terminates.
  always_comb begin
    decodedN = (bus.node_count == 4'd0) ? 5'd16 : {1'b0, bus.node_count};
    if (decodedN > MAX_N) begin
      decodedN = MAX_N;
    end
  end

  // Only COLLECT accepts beats; the last one is the beat whose index is N-1.
  assign beatFire = bus.res_valid && (state_q == COLLECT);
  assign lastBeat = ({1'b0, idx_q} == (nodeCnt_q - 5'd1));

  argmax_step #(
    .DATA_W (DATA_W)
  ) uStep (
    .bestVal_i (bestVal_q),
    .bestIdx_i (bestIdx_q),
    .resData_i (bus.res_data),
    .idx_i     (idx_q),
    .bestVal_o (stepVal),
    .bestIdx_o (stepIdx)
  );

  // Next-state logic. abort is applied last so it overrides start, a final
  // beat and the result handshake, and leaves every data register untouched.
  always_comb begin
    state_d   = state_q;
    nodeCnt_d = nodeCnt_q;
    idx_d     = idx_q;
    bestVal_d = bestVal_q;
    bestIdx_d = bestIdx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          nodeCnt_d = decodedN;
          idx_d     = '0;
          bestVal_d = BEST_INIT;
          bestIdx_d = '0;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        if (beatFire) begin
          bestVal_d = stepVal;
          bestIdx_d = stepIdx;
          idx_d     = idx_q + 1'b1;
          if (lastBeat) begin
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (bus.cls_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort) begin
      state_d   = IDLE;
      nodeCnt_d = nodeCnt_q;
      idx_d     = idx_q;
      bestVal_d = bestVal_q;
      bestIdx_d = bestIdx_q;
    end
  end

  // State and datapath registers; reset discards any partial scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      nodeCnt_q <= 5'd16;
      idx_q     <= '0;
      bestVal_q <= BEST_INIT;
      bestIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      nodeCnt_q <= nodeCnt_d;
      idx_q     <= idx_d;
      bestVal_q <= bestVal_d;
      bestIdx_q <= bestIdx_d;
    end
  end

  // Handshake flags decode straight from state; data comes from registers,
  // so nothing on res_data reaches an output combinationally.
  assign bus.res_ready      = (state_q == COLLECT);
  assign bus.cls_valid      = (state_q == RESULT);
  assign bus.busy           = (state_q != IDLE);
  assign bus.classification = {{(8-IDX_W){1'b0}}, bestIdx_q};
  assign bus.max_value      = bestVal_q;

endmodule

// File: tb/tb_classify_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_classify_seq_ctrl
// Directed bench for classify_seq_ctrl. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_classify_seq_ctrl;
  import classify_pkg::*;

  logic clk;
  logic reset_n;
  int   checkCount;
  int   failCount;

  classify_seq_ctrl_if #(.DATA_W(8)) bus ();

  classify_seq_ctrl #(
    .MAX_NODES (16),
    .DATA_W    (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
    end
  endtask

  // Issue a start pulse; returns at the falling edge of cycle t+1.
  task automatic applyStimulus(input logic [3:0] nc);
    bus.start      = 1'b1;
    bus.node_count = nc;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("res_ready at t+1", {31'b0, bus.res_ready}, 32'd1);
  endtask

  // Present one beat for one cycle.
  task automatic driveBeat(input logic [7:0] v);
    bus.res_valid = 1'b1;
    bus.res_data  = v;
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  // Accept the held classification and confirm the return to IDLE.
  task automatic takeResult(input string tag);
    bus.cls_ready = 1'b1;
    @(negedge clk);
    bus.cls_ready = 1'b0;
    checkOutput({tag, " valid dropped"}, {31'b0, bus.cls_valid}, 32'd0);
    checkOutput({tag, " idle"}, {31'b0, bus.busy}, 32'd0);
  endtask

  logic [7:0] vals1 [10];
  logic [7:0] vals4 [4];
  logic [7:0] minVal;

  initial begin
    checkCount = 0;
    failCount  = 0;
    minVal     = 8'(NEG_MIN);
    vals1 = '{8'h03, 8'hFB, 8'h07, 8'h02, 8'h07, 8'h00, 8'hFF, 8'h06, 8'h01, 8'h80};
    vals4 = '{8'hF9, 8'h0C, 8'h05, 8'h0B};

    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.node_count = 4'd0;
    bus.abort      = 1'b0;
    bus.res_valid  = 1'b0;
    bus.res_data   = 8'h00;
    bus.cls_ready  = 1'b0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst res_ready", {31'b0, bus.res_ready}, 32'd0);
    checkOutput("rst cls_valid", {31'b0, bus.cls_valid}, 32'd0);
    checkOutput("rst busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst class", {24'b0, bus.classification}, 32'h00);
    checkOutput("rst max", {24'b0, bus.max_value}, 32'h80);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic 10-node scan, tie at 7 goes to the higher index.
    applyStimulus(4'd10);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) checkOutput("t1 valid early", {31'b0, bus.cls_valid}, 32'd0);
      driveBeat(vals1[i]);
    end
    checkOutput("t1 valid", {31'b0, bus.cls_valid}, 32'd1);
    checkOutput("t1 class", {24'b0, bus.classification}, 32'h04);
    checkOutput("t1 max", {24'b0, bus.max_value}, 32'h07);
    checkOutput("t1 res_ready", {31'b0, bus.res_ready}, 32'd0);
    checkOutput("t1 busy", {31'b0, bus.busy}, 32'd1);
    takeResult("t1");

    // Full 16-node scan of all most-negative values.
    applyStimulus(4'd0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t2 valid early", {31'b0, bus.cls_valid}, 32'd0);
      driveBeat(minVal);
    end
    checkOutput("t2 valid", {31'b0, bus.cls_valid}, 32'd1);
    checkOutput("t2 class", {24'b0, bus.classification}, 32'h0F);
    checkOutput("t2 max", {24'b0, bus.max_value}, 32'h80);
    takeResult("t2");

    // Single node; extra beats in RESULT are refused.
    applyStimulus(4'd1);
    driveBeat(8'hEC);
    checkOutput("t3 valid", {31'b0, bus.cls_valid}, 32'd1);
    checkOutput("t3 class", {24'b0, bus.classification}, 32'h00);
    checkOutput("t3 max", {24'b0, bus.max_value}, 32'hEC);
    bus.res_valid = 1'b1;
    bus.res_data  = 8'h64;
    checkOutput("t3 res_ready", {31'b0, bus.res_ready}, 32'd0);
    @(negedge clk);
    bus.res_valid = 1'b0;
    checkOutput("t3 max held", {24'b0, bus.max_value}, 32'hEC);
    checkOutput("t3 class held", {24'b0, bus.classification}, 32'h00);
    takeResult("t3");

    // Stalls between beats, then consumer backpressure.
    applyStimulus(4'd4);
    for (int i = 0; i < 4; i++) begin
      driveBeat(vals4[i]);
      if (i < 3) begin
        bus.res_data = 8'h7F;
        @(negedge clk);
        checkOutput("t4 stall res_ready", {31'b0, bus.res_ready}, 32'd1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4 valid held", {31'b0, bus.cls_valid}, 32'd1);
      checkOutput("t4 class", {24'b0, bus.classification}, 32'h01);
      checkOutput("t4 max", {24'b0, bus.max_value}, 32'h0C);
      @(negedge clk);
    end
    takeResult("t4");

    // start while busy is ignored: the scan still ends after 2 beats.
    applyStimulus(4'd2);
    bus.start      = 1'b1;
    bus.node_count = 4'd5;
    driveBeat(8'h05);
    bus.start = 1'b0;
    driveBeat(8'h09);
    checkOutput("t5 valid", {31'b0, bus.cls_valid}, 32'd1);
    checkOutput("t5 class", {24'b0, bus.classification}, 32'h01);
    checkOutput("t5 max", {24'b0, bus.max_value}, 32'h09);
    takeResult("t5");

    // abort on the final beat: back to IDLE, cls_valid never rises.
    applyStimulus(4'd3);
    driveBeat(8'h01);
    driveBeat(8'h02);
    bus.abort = 1'b1;
    driveBeat(8'h03);
    bus.abort = 1'b0;
    checkOutput("t6 valid", {31'b0, bus.cls_valid}, 32'd0);
    checkOutput("t6 busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("t6 res_ready", {31'b0, bus.res_ready}, 32'd0);
    @(negedge clk);
    checkOutput("t6 valid later", {31'b0, bus.cls_valid}, 32'd0);
    applyStimulus(4'd1);
    driveBeat(8'h32);
    checkOutput("t6 restart class", {24'b0, bus.classification}, 32'h00);
    checkOutput("t6 restart max", {24'b0, bus.max_value}, 32'h32);
    takeResult("t6");

    // Asynchronous reset mid-COLLECT.
    applyStimulus(4'd4);
    driveBeat(8'h64);
    driveBeat(8'h64);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t7 busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("t7 res_ready", {31'b0, bus.res_ready}, 32'd0);
    checkOutput("t7 valid", {31'b0, bus.cls_valid}, 32'd0);
    checkOutput("t7 class", {24'b0, bus.classification}, 32'h00);
    checkOutput("t7 max", {24'b0, bus.max_value}, 32'h80);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("t7 idle after", {31'b0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/classify_seq_ctrl.md
# classify_seq_ctrl

Sequencing controller for the output-node classifier. It accepts a start command with a node count, streams the output-layer results in one per cycle over a valid/ready handshake, and tracks the running maximum and its index. It then presents the winning class on a held valid/ready output port toward the ARM-side register interface. It sits between the NN output layer and the memory-mapped result register, and replaces a wide 16-input compare tree with one registered compare stage.

## Interface
Parameters:
- MAX_NODES, 16, maximum output nodes per classification; must be a power of two ≤ 16
- DATA_W, 8, signed result width

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a classification; honoured only in IDLE
- node_count  in  4  nodes to scan, sampled on accepted start; 0 encodes 16, else 1–15
- abort  in  1  synchronous clear to IDLE from any state
- res_valid  in  1  result beat valid
- res_data  in  DATA_W  signed result of the current node, nodes in index order 0..N-1
- res_ready  out  1  high only in COLLECT
- cls_valid  out  1  classification available; held until taken
- cls_ready  in  1  consumer accepts classification
- classification  out  8  {4'b0, winning index}
- max_value  out  DATA_W  signed value of the winner
- busy  out  1  high in COLLECT and RESULT

## Operation
- FSM states: IDLE, COLLECT, RESULT.
- IDLE:
  - On start: latch N (node_count, with 0 → 16).
  - Clear beat counter idx to 0.
  - Set best_val = -128 and best_idx = 0.
  - Go to COLLECT.
- COLLECT:
  - A beat transfers when res_valid && res_ready.
  - On each transfer: if res_data >= best_val (signed), load best_val = res_data and best_idx = idx. Ties therefore resolve to the higher index.
  - idx increments on each transfer.
  - On the transfer with idx == N-1, go to RESULT.
  - A first beat of -128 always wins over the reset value, so best_idx always points at a real node.
- RESULT:
  - cls_valid = 1. classification and max_value are stable.
  - Leave to IDLE when cls_valid && cls_ready.
- start outside IDLE is ignored. It is not queued.
- abort has priority over all transitions, including start and a final beat in the same cycle. It returns to IDLE and drops cls_valid. Registers hold their values until the next start, but they are undefined to the consumer.
- Signed arithmetic only. No widening is needed. Width rule: idx and best_idx are 4 bits; N is held in 5 bits to represent 16.

## Timing
Reset values:
- state = IDLE, res_ready = 0, cls_valid = 0, busy = 0
- classification = 8'h00, max_value = 8'h80, idx = 0

Latency and throughput:
- start in cycle t → res_ready = 1 from t+1. The earliest first beat transfers at t+1.
- Throughput is 1 beat per cycle. With no stalls, N beats complete in cycles t+1..t+N.
- cls_valid rises at t+N+1, the cycle after the last beat.
- cls_ready high while cls_valid → state is IDLE in the next cycle. start can be accepted in that IDLE cycle, giving a minimum period of N+2 cycles.

Handshake rules:
- res_valid low stalls the scan with no state change.
- cls_ready may be held high early; the result transfers in the first cycle cls_valid is high.
- Outputs are all registered or decoded from state. There is no combinational path from res_data to outputs.

Reset mid-operation: asynchronous to IDLE. Partial results are discarded.

## Structure
- Package classify_pkg:
  - state enum cls_state_t {IDLE, COLLECT, RESULT}
  - localparam NEG_MIN = -128
  - localparam IDX_W = 4
- Sub-module argmax_step:
  - Combinational.
  - Inputs: best_val, best_idx, res_data, idx.
  - Outputs: next best_val and best_idx, using the >= rule.
- The top module holds the FSM, the counters and the registers.

## Test plan
- Basic 10-node scan:
  - Stimulus: start with node_count = 10; values 0..9 = {3,-5,7,2,7,0,-1,6,1,-128} back-to-back.
  - Required: cls_valid at t+11, classification = 8'h04 (tie at 7 → higher index), max_value = 7.
- Full 16-node scan with all beats -128:
  - Stimulus: node_count = 0.
  - Required: classification = 8'h0F, max_value = -128, cls_valid exactly 17 cycles after start.
- Single node:
  - Stimulus: node_count = 1, beat = -20.
  - Required: classification = 0, max_value = -20. Beats offered after RESULT are not accepted (res_ready = 0).
- Stall and backpressure:
  - Stimulus: 4 nodes with res_valid toggling; cls_ready held low for 5 cycles.
  - Required: correct argmax, cls_valid and data stable throughout, IDLE one cycle after cls_ready.
- Control corners:
  - start while busy → ignored.
  - abort coincident with the final beat → IDLE, cls_valid never rises.
  - reset_n low mid-COLLECT → all outputs return to their reset values immediately.
